// File: rtl/data_ram_ctrl.sv
// Single-port data RAM controller with RISC-V sized loads/stores, a fixed number of
// wait states per access and a valid/ready response held until the core consumes it.
module data_ram_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          err_s;
  logic          do_access_s;
  logic          mem_we_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   rdword_s;
  logic [3:0]    be_s;
  logic [31:0]   wd_s;

  // Misalignment, illegal size code (incl. unsigned sizes on stores) and out-of-range address.
  function automatic logic access_err(input logic w, input logic [31:0] a, input logic [2:0] f3);
    logic e;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = a[0];
      3'b010:  e = (a[1:0] != 2'b00);
      3'b100:  e = w;
      3'b101:  e = w | a[0];
      default: e = 1'b1;
    endcase
    return e | ((a >> (AW + 2)) != 32'd0);
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] lane, input logic [2:0] f3);
    logic [3:0] be;
    case (f3)
      3'b000:  be = 4'b0001 << lane;
      3'b001:  be = lane[1] ? 4'b1100 : 4'b0011;
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] wd, input logic [2:0] f3);
    logic [31:0] d;
    case (f3)
      3'b000:  d = {4{wd[7:0]}};
      3'b001:  d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  assign err_s       = access_err(write_q, addr_q, funct3_q);
  assign idx_s       = addr_q[AW+1:2];
  assign rdword_s    = mem_q[idx_s];
  assign do_access_s = (state_q == S_WAIT) && (cnt_q == 4'd0);
  // A reset on the access edge must suppress the write as well as the response.
  assign mem_we_s    = do_access_s && write_q && !err_s && rst_n;
  assign be_s        = store_be(addr_q[1:0], funct3_q);
  assign wd_s        = store_data(wdata_q, funct3_q);

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Next-state and response logic.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          cnt_d    = WS;
          state_d  = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_s;
          rsp_rdata_d = (err_s || write_q) ? 32'd0 : load_ext(rdword_s, addr_q[1:0], funct3_q);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      funct3_q    <= 3'd0;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage with per-byte-lane write enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) mem_q[idx_s][8*i +: 8] <= wd_s[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Randomized scoreboard bench for data_ram_ctrl: a byte-array reference model predicts
// each response, and a monitor checks data, error flag, latency and hold stability.
module tb_data_ram_ctrl;
  localparam int DEPTH = 1024;
  localparam int WS    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_funct3 = 3'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  data_ram_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [7:0]  mdl [DEPTH*4];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  bit          hold = 1'b0;
  bit          seen = 1'b0;
  bit          consumed = 1'b0;
  logic [31:0] snap_rd;
  logic        snap_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference behaviour on a flat little-endian byte array.
  function automatic void model(input bit w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] f3, output logic [31:0] rd, output bit err);
    int size;
    logic [31:0] v;
    size = 1 << f3[1:0];
    err = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (w && f3[2]) ||
          (a % size != 0) || (a >= DEPTH * 4);
    rd = 32'd0;
    if (!err) begin
      if (w) begin
        for (int i = 0; i < size; i++) mdl[a + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mdl[a + i];
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        rd = v;
      end
    end
  endfunction

  // Issue one request from a negedge; returns at the negedge after acceptance.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, input bit dir, input logic [31:0] erd,
                       input bit eerr, input bit expect_rsp);
    logic [31:0] mrd;
    bit merr;
    int t;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_funct3 = f3;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      n_chk++;
      $display("FAIL accept_timeout: req_ready=0 expected 1");
      req_valid = 1'b0;
      return;
    end
    if (expect_rsp) begin
      model(w, a, wd, f3, mrd, merr);
      sb.push_back('{dir ? erd : mrd, dir ? eerr : merr, cyc + 1});
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_funct3 = 3'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || rsp_valid || !req_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_chk++;
      $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
    end
  endtask

  task automatic wait_rsp();
    int t;
    t = 0;
    while (!rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rsp_valid) begin
      n_chk++;
      $display("FAIL rsp_timeout: rsp_valid=0 expected 1");
    end
  endtask

  // Response monitor: compares against the scoreboard and drives rsp_ready.
  always @(negedge clk) begin
    if (consumed) begin
      check("valid_drop_after_consume", 32'(rsp_valid), 32'd0);
      check("ready_after_consume", 32'(req_ready), 32'd1);
      consumed = 1'b0;
    end
    if (rsp_valid) begin
      if (!seen) begin
        seen = 1'b1;
        snap_rd = rsp_rdata;
        snap_err = rsp_err;
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_rsp: rsp_valid=1 expected 0");
        end else begin
          e = sb.pop_front();
          check("rdata", rsp_rdata, e.rd);
          check("err", 32'(rsp_err), 32'(e.err));
          check("latency", 32'(cyc - e.acc), 32'(1 + WS));
        end
      end else begin
        check("hold_rdata", rsp_rdata, snap_rd);
        check("hold_err", 32'(rsp_err), 32'(snap_err));
        check("ready_low_in_resp", 32'(req_ready), 32'd0);
      end
      rsp_ready = !hold && ($urandom_range(0, 2) != 0);
      if (rsp_ready) begin
        consumed = 1'b1;
        seen = 1'b0;
      end
    end else begin
      seen = 1'b0;
      rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b1, 32'd0, 1'b0, 1'b1);
    issue(1'b0, 32'h10, 32'd0, 3'b010, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    issue(1'b0, 32'h13, 32'd0, 3'b000, 1'b1, 32'hFFFFFFDE, 1'b0, 1'b1);
    issue(1'b0, 32'h13, 32'd0, 3'b100, 1'b1, 32'h000000DE, 1'b0, 1'b1);
    issue(1'b0, 32'h12, 32'd0, 3'b001, 1'b1, 32'hFFFFDEAD, 1'b0, 1'b1);
    issue(1'b0, 32'h10, 32'd0, 3'b101, 1'b1, 32'h0000BEEF, 1'b0, 1'b1);
    issue(1'b1, 32'h11, 32'h00000055, 3'b000, 1'b1, 32'd0, 1'b0, 1'b1);
    issue(1'b0, 32'h10, 32'd0, 3'b010, 1'b1, 32'hDEAD55EF, 1'b0, 1'b1);
    issue(1'b0, 32'h12, 32'd0, 3'b010, 1'b1, 32'd0, 1'b1, 1'b1);
    issue(1'b1, 32'h11, 32'h00001234, 3'b001, 1'b1, 32'd0, 1'b1, 1'b1);
    issue(1'b0, 32'h1000, 32'd0, 3'b010, 1'b1, 32'd0, 1'b1, 1'b1);
    issue(1'b1, 32'h10, 32'h000000AA, 3'b100, 1'b1, 32'd0, 1'b1, 1'b1);
    issue(1'b0, 32'h10, 32'd0, 3'b011, 1'b1, 32'd0, 1'b1, 1'b1);
    issue(1'b0, 32'h10, 32'd0, 3'b010, 1'b1, 32'hDEAD55EF, 1'b0, 1'b1);
    wait_idle();

    // Long stall in RESP.
    hold = 1'b1;
    issue(1'b0, 32'h10, 32'd0, 3'b010, 1'b1, 32'hDEAD55EF, 1'b0, 1'b1);
    wait_rsp();
    repeat (5) @(negedge clk);
    hold = 1'b0;
    wait_idle();

    // Store dropped by reset during WAIT.
    issue(1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 1'b1, 32'd0, 1'b0, 1'b1);
    issue(1'b1, 32'h20, 32'h12345678, 3'b010, 1'b0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("no_rsp_after_wait_reset", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    issue(1'b0, 32'h20, 32'd0, 3'b010, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    wait_idle();

    // Response discarded by reset during RESP.
    hold = 1'b1;
    issue(1'b0, 32'h20, 32'd0, 3'b010, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    wait_rsp();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hold = 1'b0;
    check("resp_rst_valid", 32'(rsp_valid), 32'd0);
    check("resp_rst_ready", 32'(req_ready), 32'd1);
    check("resp_rst_rdata", rsp_rdata, 32'd0);
    check("resp_rst_err", 32'(rsp_err), 32'd0);
    issue(1'b0, 32'h20, 32'd0, 3'b010, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    wait_idle();

    for (int i = 0; i < 64; i++) issue(1'b1, 32'(4 * i), 32'd0, 3'b010, 1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) a = a + 32'h1000 + (($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'd0);
      case ($urandom_range(0, 5))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        4: f3 = 3'b101;
        default: f3 = 3'($urandom);
      endcase
      issue(1'($urandom), a, $urandom, f3, 1'b0, 32'd0, 1'b0, 1'b1);
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_ram_ctrl.md
DATA_RAM_CTRL -- requirements
Module: data_ram_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit storage words (power of two).
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, giving extra access cycles (0..15).
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 req_valid  input  1  core presents a load/store request.
REQ-007 req_ready  output  1  block accepts a request this cycle.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 req_funct3  input  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  core consumes response.
REQ-014 rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-015 rsp_err  output  1  request faulted (misaligned, out of range, illegal funct3).

Function
REQ-016 Storage SHALL be DEPTH_WORDS x 32, little-endian, word index = req_addr[log2(DEPTH_WORDS)+1:2].
REQ-017 FSM states SHALL be IDLE, WAIT, RESP; req_ready = 1 only in IDLE (combinational from state).
REQ-018 IDLE: req_valid=1 at a rising edge latches write, addr, wdata, funct3, wait counter = WAIT_STATES, next state WAIT.
REQ-019 WAIT: counter decrements each cycle; when counter = 0, access is performed and state moves to RESP on the same edge.
REQ-020 Latency: request accepted at edge N -> rsp_valid high after edge N+1+WAIT_STATES.
REQ-021 RESP: rsp_valid, rsp_rdata, rsp_err held stable until rsp_ready=1 at an edge; then IDLE, rsp_valid=0.
REQ-022 Back-to-back: no new request is accepted in the response-consume cycle; next acceptance earliest one edge later (req_ready high in IDLE).
REQ-023 Loads: B/H sign-extend, BU/HU zero-extend, W unchanged; byte lane = addr[1:0], halfword lane = addr[1].
REQ-024 Stores: only the addressed byte lanes SHALL be written (SB 1 lane, SH 2 lanes, SW 4 lanes); other lanes unchanged.
REQ-025 Misaligned (H with addr[0]=1, W with addr[1:0]!=0) SHALL set rsp_err=1, rsp_rdata=0, no memory write.
REQ-026 Address with any bit above the word-index field set SHALL set rsp_err=1, no write.
REQ-027 Illegal funct3 (011, 11x, or BU/HU for store) SHALL set rsp_err=1, no write.
REQ-028 Error responses SHALL take the same latency as normal accesses.
REQ-029 Inputs other than rsp_ready SHALL be ignored outside IDLE.
REQ-030 A load issued after a store response to the same address SHALL return the stored value.

Reset
REQ-031 rst_n=0 at an edge SHALL force IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0; req_ready 1 thereafter.
REQ-032 Reset in WAIT SHALL drop the pending request; a store not yet performed SHALL NOT write memory.
REQ-033 Reset in RESP SHALL discard the response without handshake.
REQ-034 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-035 SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata 0xDEADBEEF, err 0, rsp_valid 3 edges after each acceptance (WAIT_STATES=2).
REQ-036 After REQ-035: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
REQ-037 SB 0x55 @0x11 then LW @0x10 -> 0xDEAD55EF.
REQ-038 LW @0x12, SH @0x11, LW @0x1000 (DEPTH_WORDS=1024) -> each err 1, rdata 0; following LW @0x10 unchanged.
REQ-039 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata, err stable, req_ready 0; consume -> req_ready 1 next cycle.
REQ-040 SW 0x12345678 @0x20, assert rst_n=0 during WAIT -> no response; LW @0x20 returns prior contents.
